// File: rtl/slot_bus_if.sv
// Apple II slot bus front end: synchronises the raw bus strobes, classifies each access,
// tracks $C800 ownership, issues register strobes and sequences the delayed data-bus drive.
module slot_bus_if #(
   parameter int SYNC_STAGES  = 2,
   parameter int OE_DELAY     = 2,
   parameter bit Q3_GATE      = 1'b1,
   parameter bit READ_A0_ONLY = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] addr,
   input  logic        rw,
   input  logic        q3,
   input  logic        _devsel,
   input  logic        _iosel,
   input  logic        _iostrobe,
   input  logic [7:0]  data_in,
   input  logic [7:0]  rom_data,
   input  logic [7:0]  reg_data,
   output logic [11:0] rom_addr,
   output logic [3:0]  reg_addr,
   output logic        reg_rd,
   output logic        reg_wr,
   output logic [7:0]  reg_wdata,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        _en245,
   output logic        exp_active
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DRIVE} state_t;
   typedef enum logic [1:0] {K_NONE, K_DEV, K_IOSEL, K_STRB} kind_t;

   localparam int SW = 25;
   localparam logic [SW-1:0] SYNC_IDLE = 25'h700;  // the three strobes rest high
   localparam int CW = (OE_DELAY > 1) ? $clog2(OE_DELAY) : 1;
   localparam logic [CW-1:0] CNT_INIT = (OE_DELAY > 0) ? CW'(OE_DELAY - 1) : '0;

   logic [SW-1:0] sync_q [SYNC_STAGES];
   logic [SW-1:0] sync_out;
   logic [11:0]   addr_s;
   logic          rw_s, q3_s, devsel_n_s, iosel_n_s, strb_n_s;
   logic [7:0]    data_s;
   logic [2:0]    strb_prev;

   state_t        state;
   kind_t         kind_q, start_kind;
   logic [CW-1:0] cnt;
   logic          rw_q, rom_sel_q, oe_ok_q, wr_pend;
   logic          dev_fall, io_fall, strb_fall;
   logic          is_cfff, start_rom, start_ok, start_oe, q3_ok, sel_cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
      end else begin
         // NOTE: non-blocking, so every stage takes its neighbour's old value and the chain really shifts
         sync_q[0] <= {addr, rw, q3, _devsel, _iosel, _iostrobe, data_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out   = sync_q[SYNC_STAGES-1];
   assign addr_s     = sync_out[24:13];
   assign rw_s       = sync_out[12];
   assign q3_s       = sync_out[11];
   assign devsel_n_s = sync_out[10];
   assign iosel_n_s  = sync_out[9];
   assign strb_n_s   = sync_out[8];
   assign data_s     = sync_out[7:0];

   assign dev_fall  = strb_prev[2] & ~devsel_n_s;
   assign io_fall   = strb_prev[1] & ~iosel_n_s;
   assign strb_fall = strb_prev[0] & ~strb_n_s;

   always_comb begin
      // NOTE: default first so no path holds the old value, which would infer a latch
      start_kind = K_NONE;
      if (state == S_IDLE) begin
         if (dev_fall)       start_kind = K_DEV;
         else if (io_fall)   start_kind = K_IOSEL;
         else if (strb_fall) start_kind = K_STRB;
      end
   end

   // A $CFFF strobe hands ownership away, so it is never driven even while owned.
   assign is_cfff   = (addr_s[10:0] == 11'h7FF);
   assign start_rom = (start_kind == K_IOSEL) ||
                      (start_kind == K_STRB && exp_active && !is_cfff);
   assign start_ok  = (start_kind == K_DEV) || start_rom;
   assign start_oe  = rw_s && (start_rom ||
                      (start_kind == K_DEV && (!READ_A0_ONLY || !addr_s[0])));
   assign q3_ok     = !Q3_GATE || !q3_s;
   assign sel_cur   = (kind_q == K_DEV)   ? !devsel_n_s :
                      (kind_q == K_IOSEL) ? !iosel_n_s  :
                      (kind_q == K_STRB)  ? !strb_n_s   : 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         kind_q     <= K_NONE;
         rw_q       <= 1'b0;
         rom_sel_q  <= 1'b0;
         oe_ok_q    <= 1'b0;
         wr_pend    <= 1'b0;
         strb_prev  <= 3'b111;
         rom_addr   <= '0;
         reg_addr   <= '0;
         reg_rd     <= 1'b0;
         reg_wr     <= 1'b0;
         reg_wdata  <= '0;
         data_out   <= '0;
         data_oe    <= 1'b0;
         _en245     <= 1'b1;
         exp_active <= 1'b0;
      end else begin
         strb_prev <= {devsel_n_s, iosel_n_s, strb_n_s};
         reg_rd    <= 1'b0;
         reg_wr    <= 1'b0;
         data_out  <= rom_sel_q ? rom_data :
                      (kind_q == K_DEV && rw_q) ? reg_data : 8'h00;

         if (start_kind != K_NONE) begin
            kind_q    <= start_kind;
            rom_addr  <= addr_s;
            reg_addr  <= addr_s[3:0];
            rw_q      <= rw_s;
            rom_sel_q <= start_rom;
            oe_ok_q   <= start_oe;
            if (start_kind == K_IOSEL)
               exp_active <= 1'b1;
            else if (start_kind == K_STRB && is_cfff)
               exp_active <= 1'b0;
            if (start_kind == K_DEV) begin
               reg_rd  <= rw_s;
               wr_pend <= !rw_s;
            end
         end

         // Write data follows the bus for the whole access; reg_wr fires once _devsel is gone.
         if ((wr_pend || (start_kind == K_DEV && !rw_s)) && !devsel_n_s)
            reg_wdata <= data_s;
         if (wr_pend && devsel_n_s) begin
            reg_wr  <= 1'b1;
            wr_pend <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  if (OE_DELAY == 0) begin
                     state   <= S_DRIVE;
                     data_oe <= start_oe;
                     _en245  <= !q3_ok;
                  end else begin
                     state <= S_SETTLE;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_SETTLE: begin
               if (!sel_cur) begin
                  state <= S_IDLE;
               end else if (cnt == '0) begin
                  state   <= S_DRIVE;
                  data_oe <= oe_ok_q;
                  _en245  <= !q3_ok;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DRIVE: begin
               if (!sel_cur) begin
                  state   <= S_IDLE;
                  data_oe <= 1'b0;
                  _en245  <= 1'b1;
               end else begin
                  _en245 <= !q3_ok;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_slot_bus_if.sv
// Bench for slot_bus_if: two configurations (OE_DELAY=2 gated, OE_DELAY=0 ungated) against
// an access-level model of timing windows, ownership and register strobes.
module tb_slot_bus_if;

   localparam int SYNC = 2;
   localparam int OE_A = 2;
   localparam int OE_B = 0;
   localparam logic [7:0] REG_BASE = 8'h96;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] addr;
   logic        rw, q3, devsel_n, iosel_n, strobe_n;
   logic [7:0]  data_in;

   logic [11:0] rom_addr_a, rom_addr_b;
   logic [3:0]  reg_addr_a, reg_addr_b;
   logic        reg_rd_a, reg_rd_b, reg_wr_a, reg_wr_b;
   logic [7:0]  reg_wdata_a, reg_wdata_b, data_out_a, data_out_b;
   logic        data_oe_a, data_oe_b, en245_a, en245_b, exp_a, exp_b;
   logic [7:0]  rom_data_a, rom_data_b, reg_data_a, reg_data_b;

   int n_checks = 0;
   int n_pass   = 0;
   bit own      = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_model(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], 4'h3};
   endfunction

   function automatic logic [7:0] reg_model(input logic [3:0] a);
      return REG_BASE ^ {4'h0, a ^ 4'hC};
   endfunction

   assign rom_data_a = rom_model(rom_addr_a);
   assign rom_data_b = rom_model(rom_addr_b);
   assign reg_data_a = reg_model(reg_addr_a);
   assign reg_data_b = reg_model(reg_addr_b);

   slot_bus_if #(.SYNC_STAGES(SYNC), .OE_DELAY(OE_A), .Q3_GATE(1'b1), .READ_A0_ONLY(1'b1)) u_a (
      .clk(clk), .reset(reset), .addr(addr), .rw(rw), .q3(q3),
      ._devsel(devsel_n), ._iosel(iosel_n), ._iostrobe(strobe_n),
      .data_in(data_in), .rom_data(rom_data_a), .reg_data(reg_data_a),
      .rom_addr(rom_addr_a), .reg_addr(reg_addr_a), .reg_rd(reg_rd_a), .reg_wr(reg_wr_a),
      .reg_wdata(reg_wdata_a), .data_out(data_out_a), .data_oe(data_oe_a),
      ._en245(en245_a), .exp_active(exp_a));

   slot_bus_if #(.SYNC_STAGES(SYNC), .OE_DELAY(OE_B), .Q3_GATE(1'b0), .READ_A0_ONLY(1'b0)) u_b (
      .clk(clk), .reset(reset), .addr(addr), .rw(rw), .q3(q3),
      ._devsel(devsel_n), ._iosel(iosel_n), ._iostrobe(strobe_n),
      .data_in(data_in), .rom_data(rom_data_b), .reg_data(reg_data_b),
      .rom_addr(rom_addr_b), .reg_addr(reg_addr_b), .reg_rd(reg_rd_b), .reg_wr(reg_wr_b),
      .reg_wdata(reg_wdata_b), .data_out(data_out_b), .data_oe(data_oe_b),
      ._en245(en245_b), .exp_active(exp_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_inst(input string nm, input int n,
                             input logic oe, input logic en, input logic rd, input logic wr,
                             input logic ex, input logic [7:0] dout,
                             input logic e_oe, input logic e_en, input logic e_rd,
                             input logic e_wr, input logic e_ex,
                             input logic chk_d, input logic [7:0] e_d);
      check($sformatf("%s.data_oe@%0d", nm, n), 32'(oe), 32'(e_oe));
      check($sformatf("%s.en245@%0d", nm, n), 32'(en), 32'(e_en));
      check($sformatf("%s.reg_rd@%0d", nm, n), 32'(rd), 32'(e_rd));
      check($sformatf("%s.reg_wr@%0d", nm, n), 32'(wr), 32'(e_wr));
      check($sformatf("%s.exp_active@%0d", nm, n), 32'(ex), 32'(e_ex));
      if (chk_d) check($sformatf("%s.data_out@%0d", nm, n), 32'(dout), 32'(e_d));
   endtask

   // kind: 0 = _devsel, 1 = _iosel, 2 = _iostrobe. The strobe is low on raw edges 1..h;
   // the address is valid only on edge 1, q3 is high on raw edges q3_lo..q3_hi.
   task automatic access(input int kind, input logic [11:0] a, input logic rwv,
                         input logic [7:0] wd, input int h, input int q3_lo, input int q3_hi);
      bit cfff, rom_sel, own_new, valid, drv_a, drv_b, win_a, win_b, q3_at, low;
      logic [7:0] dexp;
      int last;
      cfff    = (a[10:0] == 11'h7FF);
      rom_sel = (kind == 1) || (kind == 2 && own && !cfff);
      own_new = (kind == 1) ? 1'b1 : (kind == 2 && cfff) ? 1'b0 : own;
      valid   = (kind == 0) || rom_sel;
      drv_a   = rwv && (rom_sel || (kind == 0 && !a[0]));
      drv_b   = rwv && (rom_sel || kind == 0);
      dexp    = rom_sel ? rom_model(a) : (kind == 0 && rwv) ? reg_model(a[3:0]) : 8'h00;
      last    = h + SYNC + 2;
      rw      = rwv;
      for (int n = 1; n <= last; n++) begin
         low      = (n <= h);
         addr     = (n == 1) ? a : ~a;
         devsel_n = !(low && kind == 0);
         iosel_n  = !(low && kind == 1);
         strobe_n = !(low && kind == 2);
         q3       = (n >= q3_lo && n <= q3_hi);
         data_in  = (n == 1 && h >= 2) ? ~wd : wd;
         step();
         win_a = valid && n >= SYNC + 1 + OE_A && n <= h + SYNC;
         win_b = valid && n >= SYNC + 1 + OE_B && n <= h + SYNC;
         q3_at = (n - SYNC >= q3_lo && n - SYNC <= q3_hi);
         check_inst("a", n, data_oe_a, en245_a, reg_rd_a, reg_wr_a, exp_a, data_out_a,
                    win_a && drv_a, !(win_a && !q3_at),
                    kind == 0 && rwv && n == SYNC + 1, kind == 0 && !rwv && n == h + SYNC + 1,
                    (n >= SYNC + 1) ? own_new : own, win_a && n >= SYNC + 2, dexp);
         check_inst("b", n, data_oe_b, en245_b, reg_rd_b, reg_wr_b, exp_b, data_out_b,
                    win_b && drv_b, !win_b,
                    kind == 0 && rwv && n == SYNC + 1, kind == 0 && !rwv && n == h + SYNC + 1,
                    (n >= SYNC + 1) ? own_new : own, win_b && n >= SYNC + 2, dexp);
      end
      own = own_new;
      q3  = 1'b0;
      check("a.rom_addr", 32'(rom_addr_a), 32'(a));
      check("b.rom_addr", 32'(rom_addr_b), 32'(a));
      check("a.reg_addr", 32'(reg_addr_a), 32'(a[3:0]));
      check("b.reg_addr", 32'(reg_addr_b), 32'(a[3:0]));
      if (kind == 0 && !rwv) begin
         check("a.reg_wdata", 32'(reg_wdata_a), 32'(wd));
         check("b.reg_wdata", 32'(reg_wdata_b), 32'(wd));
      end
   endtask

   initial begin
      int k, h, qlo, qhi;
      logic [11:0] ra;

      reset = 1'b1; addr = '0; rw = 1'b1; q3 = 1'b0; data_in = '0;
      devsel_n = 1'b1; iosel_n = 1'b1; strobe_n = 1'b1;
      repeat (3) step();
      check("rst.a.en245", 32'(en245_a), 32'd1);
      check("rst.b.en245", 32'(en245_b), 32'd1);
      check("rst.a.data_oe", 32'(data_oe_a), 32'd0);
      check("rst.a.exp_active", 32'(exp_a), 32'd0);
      check("rst.a.rom_addr", 32'(rom_addr_a), 32'd0);
      check("rst.a.reg_addr", 32'(reg_addr_a), 32'd0);
      check("rst.a.reg_rd", 32'(reg_rd_a), 32'd0);
      check("rst.a.reg_wr", 32'(reg_wr_a), 32'd0);
      check("rst.a.reg_wdata", 32'(reg_wdata_a), 32'd0);
      check("rst.a.data_out", 32'(data_out_a), 32'd0);
      reset = 1'b0;
      step();

      // Register read, register write, A0-qualified read
      access(0, 12'h0EC, 1'b1, 8'h00, 6, 0, -1);
      access(0, 12'h0E3, 1'b0, 8'h5A, 6, 0, -1);
      access(0, 12'h0E3, 1'b1, 8'h00, 5, 0, -1);
      // Slot ROM, owned expansion ROM, $CFFF release, unowned expansion ROM
      access(1, 12'h500, 1'b1, 8'h00, 6, 0, -1);
      access(2, 12'h812, 1'b1, 8'h00, 6, 0, -1);
      access(2, 12'hFFF, 1'b1, 8'h00, 6, 0, -1);
      access(2, 12'h812, 1'b1, 8'h00, 6, 0, -1);
      // Short select glitch, then q3 high in the middle of a drive
      access(0, 12'h0E0, 1'b1, 8'h00, 1, 0, -1);
      access(0, 12'h0EC, 1'b1, 8'h00, 8, 5, 6);

      // Reset while driving a slot ROM read with the select still held
      addr = 12'h5A7; rw = 1'b1; iosel_n = 1'b0;
      repeat (SYNC + 1 + OE_A) step();
      check("rst_mid.pre.a.data_oe", 32'(data_oe_a), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      own = 1'b0;
      check("rst_mid.a.data_oe", 32'(data_oe_a), 32'd0);
      check("rst_mid.a.en245", 32'(en245_a), 32'd1);
      check("rst_mid.a.exp_active", 32'(exp_a), 32'd0);
      check("rst_mid.b.data_oe", 32'(data_oe_b), 32'd0);
      check("rst_mid.b.en245", 32'(en245_b), 32'd1);
      check("rst_mid.a.data_out", 32'(data_out_a), 32'd0);
      for (int n = 1; n <= 6; n++) begin
         step();
         check($sformatf("rst_mid.a.data_oe@%0d", n), 32'(data_oe_a), 32'(n >= SYNC + 1 + OE_A));
         check($sformatf("rst_mid.b.data_oe@%0d", n), 32'(data_oe_b), 32'(n >= SYNC + 1 + OE_B));
         check($sformatf("rst_mid.a.exp_active@%0d", n), 32'(exp_a), 32'(n >= SYNC + 1));
      end
      check("rst_mid.b.data_out", 32'(data_out_b), 32'(rom_model(12'h5A7)));
      own = 1'b1;
      iosel_n = 1'b1;
      repeat (SYNC + 1) step();
      check("rst_mid.rel.a.data_oe", 32'(data_oe_a), 32'd0);
      check("rst_mid.rel.a.en245", 32'(en245_a), 32'd1);
      check("rst_mid.rel.b.en245", 32'(en245_b), 32'd1);

      // Randomised accesses
      for (int i = 0; i < 24; i++) begin
         k = $urandom_range(0, 2);
         case (k)
            0:       ra = {4'h0, 4'hE, 4'($urandom)};
            1:       ra = {4'h5, 8'($urandom)};
            default: ra = ($urandom_range(0, 3) == 0) ? 12'hFFF : {1'b1, 11'($urandom)};
         endcase
         h   = $urandom_range(1, 6);
         qlo = $urandom_range(1, 10);
         qhi = ($urandom_range(0, 1) == 0) ? -1 : qlo + $urandom_range(0, 3);
         access(k, ra, 1'($urandom), 8'($urandom), h, qlo, qhi);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
